// File: rtl/pe_pkg.sv
// Shared PE post-processing definitions: result/byte widths, packing geometry,
// saturation limits and the shift/ReLU/saturate requantizer.
package pe_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int PDATA_WIDTH = 16;
  localparam int PACK_NUM    = 6;
  localparam int WORD_WIDTH  = DATA_WIDTH * PACK_NUM;
  localparam int FIFO_DEPTH  = 4;
  localparam int BYTES_W     = 3;

  localparam logic signed [PDATA_WIDTH-1:0] SAT_MAX = PDATA_WIDTH'(127);
  localparam logic signed [PDATA_WIDTH-1:0] SAT_MIN = PDATA_WIDTH'(-128);

  function automatic logic signed [DATA_WIDTH-1:0] requantize(
    input logic signed [PDATA_WIDTH-1:0] res,
    input logic        [3:0]             shift,
    input logic                          relu
  );
    logic signed [PDATA_WIDTH-1:0] s;
    s = res >>> shift;
    if (relu && s[PDATA_WIDTH-1]) s = '0;
    if (s > SAT_MAX)      requantize = SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) requantize = SAT_MIN[DATA_WIDTH-1:0];
    else                  requantize = s[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pe_result_packer_if.sv
// Output word stream of the result packer toward activation write-back.
interface pe_result_packer_if #(
  parameter int WORD_WIDTH = 48
);
  logic                  o_valid;
  logic [WORD_WIDTH-1:0] o_data;
  logic [2:0]            o_bytes;
  logic                  i_ready;

  modport master (output o_valid, o_data, o_bytes, input i_ready);
  modport slave  (input o_valid, o_data, o_bytes, output i_ready);
endinterface

// File: rtl/pe_out_fifo.sv
// Synchronous FIFO with up to two pushes and one pop per cycle; the head is
// held in a register so it keeps its last value once the FIFO drains.
module pe_out_fifo #(
  parameter int W     = 51,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push0,
  input  logic          push1,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count_q, remain, count_nxt;
  logic [W-1:0]  dout_q, head_nxt;

  always_comb begin
    remain    = count_q - CW'(pop);
    count_nxt = remain + CW'(push0) + CW'(push1);
    rd_nxt    = rd_ptr + AW'(pop);
    head_nxt  = dout_q;
    // Surviving entries sit ahead of anything written this cycle.
    if (remain != '0)  head_nxt = mem[rd_nxt];
    else if (push0)    head_nxt = din0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr  <= rd_nxt;
      count_q <= count_nxt;
      dout_q  <= head_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push0) mem[wr_ptr] <= din0;
    if (push1) mem[wr_ptr + AW'(1)] <= din1;
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/pe_result_packer.sv
// Requantizes PE partial sums to bytes and packs them into row-wide words.
// Optional ReLU honoured only when PE_PACK_RELU_EN is defined.
module pe_result_packer
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH_P  = DATA_WIDTH,
  parameter int PDATA_WIDTH_P = PDATA_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  input  logic [1:0]                      i_res_mask,
  input  logic signed [PDATA_WIDTH_P-1:0] i_result0,
  input  logic signed [PDATA_WIDTH_P-1:0] i_result1,
  input  logic [3:0]                      i_out_shift,
  input  logic                            i_relu,
  input  logic                            i_flush,
  output logic                            o_in_ready,
  output logic                            o_overflow,
  pe_result_packer_if.master              out_if
);

  localparam int FW = WORD_WIDTH + BYTES_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic relu_en;
`ifdef PE_PACK_RELU_EN
  assign relu_en = i_relu;
`else
  logic unused_relu;
  assign unused_relu = i_relu;
  assign relu_en     = 1'b0;
`endif

  logic [PACK_NUM-1:0][DATA_WIDTH_P-1:0] pack_buf_p0, pack_buf_nxt;
  logic [BYTES_W-1:0]                    byte_cnt_p0, cnt_nxt;
  logic                                  overflow_p0;
  logic signed [DATA_WIDTH_P-1:0]        qbyte [2];
  logic                                  take, push0, push1, pop;
  logic [FW-1:0]                         word0, word1, fifo_head;
  logic [CW-1:0]                         fifo_count;

  assign o_in_ready = (fifo_count <= CW'(FIFO_DEPTH - 2));
  assign take       = o_in_ready;
  assign qbyte[0]   = requantize(i_result0, i_out_shift, relu_en);
  assign qbyte[1]   = requantize(i_result1, i_out_shift, relu_en);

  always_comb begin
    pack_buf_nxt = pack_buf_p0;
    cnt_nxt      = byte_cnt_p0;
    push0        = 1'b0;
    push1        = 1'b0;
    word0        = '0;
    word1        = '0;
    // result0 lands first; a full word is emitted the moment it fills, so a
    // second byte spills into the next word within the same cycle.
    for (int k = 0; k < 2; k++) begin
      if (i_valid && take && i_res_mask[k]) begin
        pack_buf_nxt[cnt_nxt] = qbyte[k];
        cnt_nxt = cnt_nxt + 3'd1;
        if (cnt_nxt == BYTES_W'(PACK_NUM)) begin
          push0        = 1'b1;
          word0        = {BYTES_W'(PACK_NUM), pack_buf_nxt};
          pack_buf_nxt = '0;
          cnt_nxt      = '0;
        end
      end
    end
    if (i_flush && take && cnt_nxt != '0) begin
      if (!push0) begin
        push0 = 1'b1;
        word0 = {cnt_nxt, pack_buf_nxt};
      end else begin
        push1 = 1'b1;
        word1 = {cnt_nxt, pack_buf_nxt};
      end
      pack_buf_nxt = '0;
      cnt_nxt      = '0;
    end
  end

  // Stage 0: pack buffer, byte count and sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pack_buf_p0 <= '0;
      byte_cnt_p0 <= '0;
      overflow_p0 <= 1'b0;
    end else begin
      pack_buf_p0 <= pack_buf_nxt;
      byte_cnt_p0 <= cnt_nxt;
      if (i_valid && !take) overflow_p0 <= 1'b1;
    end
  end

  assign pop = out_if.o_valid & out_if.i_ready;

  pe_out_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push0   (push0),
    .push1   (push1),
    .din0    (word0),
    .din1    (word1),
    .pop     (pop),
    .dout    (fifo_head),
    .count   (fifo_count)
  );

  assign out_if.o_valid = (fifo_count != '0);
  assign out_if.o_data  = fifo_head[WORD_WIDTH-1:0];
  assign out_if.o_bytes = fifo_head[FW-1:WORD_WIDTH];
  assign o_overflow     = overflow_p0;

endmodule

// File: tb/tb_pe_result_packer.sv
// Directed bench for pe_result_packer; expected words are hand-computed.
module tb_pe_result_packer;
  import pe_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [1:0]  i_res_mask;
  logic signed [15:0] i_result0, i_result1;
  logic [3:0]  i_out_shift;
  logic        i_relu;
  logic        i_flush;
  logic        o_in_ready;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pe_result_packer_if #(.WORD_WIDTH(48)) bus ();

  pe_result_packer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_res_mask  (i_res_mask),
    .i_result0   (i_result0),
    .i_result1   (i_result1),
    .i_out_shift (i_out_shift),
    .i_relu      (i_relu),
    .i_flush     (i_flush),
    .o_in_ready  (o_in_ready),
    .o_overflow  (o_overflow),
    .out_if      (bus)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [15:0] r0, input logic [15:0] r1,
                      input logic [3:0] sh, input logic fl);
    i_valid     = 1'b1;
    i_res_mask  = m;
    i_result0   = r0;
    i_result1   = r1;
    i_out_shift = sh;
    i_flush     = fl;
    tick();
    i_valid    = 1'b0;
    i_flush    = 1'b0;
    i_res_mask = 2'b00;
  endtask

  task automatic flush_only();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  logic [47:0] sat_exp;

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_res_mask = 2'b00; i_result0 = '0; i_result1 = '0;
    i_out_shift = '0; i_relu = 1'b0; i_flush = 1'b0; bus.i_ready = 1'b0;
    repeat (2) tick();

    chk_eq("rst_valid",    64'(bus.o_valid), 64'd0);
    chk_eq("rst_data",     64'(bus.o_data),  64'd0);
    chk_eq("rst_bytes",    64'(bus.o_bytes), 64'd0);
    chk_eq("rst_overflow", 64'(o_overflow),  64'd0);
    chk_eq("rst_in_ready", 64'(o_in_ready),  64'd1);
    i_rst_n = 1'b1;
    tick();

    // 6 beats of result1 only: 0x0100 >>> 4 = 0x10
    for (int i = 0; i < 5; i++) beat(2'b10, 16'h7FFF, 16'h0100, 4'd4, 1'b0);
    chk_eq("6x6_not_yet", 64'(bus.o_valid), 64'd0);
    beat(2'b10, 16'h7FFF, 16'h0100, 4'd4, 1'b0);
    chk_eq("6x6_valid", 64'(bus.o_valid), 64'd1);
    chk_eq("6x6_data",  64'(bus.o_data),  64'h1010_1010_1010);
    chk_eq("6x6_bytes", 64'(bus.o_bytes), 64'd6);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk_eq("6x6_popped", 64'(bus.o_valid), 64'd0);
    chk_eq("6x6_hold",   64'(bus.o_data),  64'h1010_1010_1010);

    // Saturation plus a negative in-range value (-300 >>> 2 = -75 = 0xB5)
    i_relu = 1'b1;
    beat(2'b01, 16'h7FFF, 16'h0000, 4'd0, 1'b0);
    beat(2'b01, 16'h8000, 16'h0000, 4'd0, 1'b0);
    beat(2'b01, 16'hFED4, 16'h0000, 4'd2, 1'b0);
    flush_only();
`ifdef PE_PACK_RELU_EN
    sat_exp = 48'h0000_0000_007F;
`else
    sat_exp = 48'h0000_00B5_807F;
`endif
    chk_eq("sat_valid", 64'(bus.o_valid), 64'd1);
    chk_eq("sat_data",  64'(bus.o_data),  64'(sat_exp));
    chk_eq("sat_bytes", 64'(bus.o_bytes), 64'd3);
    i_relu = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk_eq("sat_popped", 64'(bus.o_valid), 64'd0);

    // Spill plus flush: count 5, then a two-byte beat with flush
    beat(2'b11, 16'h0011, 16'h0022, 4'd0, 1'b0);
    beat(2'b11, 16'h0033, 16'h0044, 4'd0, 1'b0);
    beat(2'b01, 16'h0055, 16'h0000, 4'd0, 1'b0);
    beat(2'b11, 16'h0066, 16'h0077, 4'd0, 1'b1);
    chk_eq("spill_w1_data",  64'(bus.o_data),  64'h6655_4433_2211);
    chk_eq("spill_w1_bytes", 64'(bus.o_bytes), 64'd6);
    chk_eq("spill_in_ready", 64'(o_in_ready),  64'd1);
    bus.i_ready = 1'b1;
    tick();
    chk_eq("spill_w2_data",  64'(bus.o_data),  64'h0000_0000_0077);
    chk_eq("spill_w2_bytes", 64'(bus.o_bytes), 64'd1);
    tick();
    bus.i_ready = 1'b0;
    chk_eq("spill_drained", 64'(bus.o_valid), 64'd0);

    // Backpressure: three full words fill the FIFO to its ready threshold
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 3; j++) beat(2'b11, 16'(k), 16'(k), 4'd0, 1'b0);
      chk_eq("bp_in_ready", 64'(o_in_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    beat(2'b11, 16'h0055, 16'h0055, 4'd0, 1'b0);
    chk_eq("bp_overflow", 64'(o_overflow), 64'd1);
    tick();
    chk_eq("bp_stall_data", 64'(bus.o_data), 64'h0101_0101_0101);
    bus.i_ready = 1'b1;
    tick();
    chk_eq("bp_w2", 64'(bus.o_data), 64'h0202_0202_0202);
    tick();
    chk_eq("bp_w3", 64'(bus.o_data), 64'h0303_0303_0303);
    tick();
    bus.i_ready = 1'b0;
    chk_eq("bp_drained", 64'(bus.o_valid), 64'd0);
    flush_only();
    chk_eq("bp_dropped", 64'(bus.o_valid), 64'd0);
    chk_eq("bp_sticky",  64'(o_overflow),  64'd1);

    // Reset mid-word: two queued words plus three buffered bytes
    for (int j = 0; j < 6; j++) beat(2'b11, 16'h0001, 16'h0002, 4'd0, 1'b0);
    beat(2'b11, 16'h0003, 16'h0004, 4'd0, 1'b0);
    beat(2'b01, 16'h0005, 16'h0000, 4'd0, 1'b0);
    chk_eq("mid_valid", 64'(bus.o_valid), 64'd1);
    #3 i_rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_valid",    64'(bus.o_valid), 64'd0);
    chk_eq("mid_rst_data",     64'(bus.o_data),  64'd0);
    chk_eq("mid_rst_bytes",    64'(bus.o_bytes), 64'd0);
    chk_eq("mid_rst_overflow", 64'(o_overflow),  64'd0);
    chk_eq("mid_rst_in_ready", 64'(o_in_ready),  64'd1);
    tick();
    i_rst_n = 1'b1;
    flush_only();
    chk_eq("mid_flush_empty", 64'(bus.o_valid), 64'd0);

    // Empty flush and mask=00 beats push nothing; count stays at 0
    beat(2'b00, 16'h0012, 16'h0034, 4'd0, 1'b0);
    beat(2'b00, 16'h0056, 16'h0078, 4'd0, 1'b1);
    flush_only();
    chk_eq("empty_no_push", 64'(bus.o_valid), 64'd0);
    beat(2'b01, 16'h0009, 16'h0000, 4'd0, 1'b1);
    chk_eq("empty_after_data", 64'(bus.o_data),  64'h0000_0000_0009);
    chk_eq("empty_after_bytes", 64'(bus.o_bytes), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
